mul_booth_seq: RTL and testbench



---
 rtl/mul_booth_seq_if.sv | 29 ++
 rtl/mul_booth_seq.sv | 121 ++++++++++++
 tb/tb_mul_booth_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_booth_seq_if.sv
// Port bundle for the sequential Booth multiplier: CPU-side start/result
// signals plus the request/grant port to the shared 32-bit adder.
interface mul_booth_seq_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        add_req;
    logic        add_gnt;
    logic [31:0] add_ra;
    logic [31:0] add_rb;
    logic        add_cin;
    logic [31:0] add_rc;

    // The multiplier is the slave; the master is the CPU together with the adder.
    modport slave (
        input  start, op_a, op_b, add_gnt, add_rc,
        output ready, busy, done, hi, lo, add_req, add_ra, add_rb, add_cin
    );

    modport master (
        output start, op_a, op_b, add_gnt, add_rc,
        input  ready, busy, done, hi, lo, add_req, add_ra, add_rb, add_cin
    );
endinterface

// File: rtl/mul_booth_seq.sv
// Sequential signed 32x32->64 radix-2 Booth multiplier that borrows the
// shared CLA adder one granted iteration at a time and returns HI/LO.
module mul_booth_seq (
    input  logic           clock,
    input  logic           reset_n,
    mul_booth_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] acc;
    logic [31:0] q;
    logic        q_m1;
    logic [31:0] m;
    logic [5:0]  cnt;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        fire;
    logic        last;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        cin;
    logic        ovf;
    logic        sgn;
    logic [31:0] acc_sh;
    logic [31:0] q_sh;

    // An iteration commits only on a cycle where the adder is actually ours.
    assign fire = (state == S_CALC) && bus.add_gnt;
    assign last = fire && (cnt == 6'd31);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that leaves it unassigned infers a latch.
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_CALC;
            S_CALC:  if (last)      state_nx = S_DONE;
            S_DONE:                 state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    // Booth select; operands are a pure function of held registers, so they
    // stay stable across ungranted cycles.
    always_comb begin
        ra  = 32'd0;
        rb  = 32'd0;
        cin = 1'b0;
        if (state == S_CALC) begin
            ra = acc;
            case ({q[0], q_m1})
                2'b01:   rb = m;
                2'b10: begin
                    rb  = ~m;
                    cin = 1'b1;
                end
                default: rb = 32'd0;
            endcase
        end
    end

    // The 33rd bit of A+/-M is recovered from the overflow flag, which keeps
    // M = -2^31 correct when subtracting.
    assign ovf    = (ra[31] == rb[31]) && (bus.add_rc[31] != ra[31]);
    assign sgn    = bus.add_rc[31] ^ ovf;
    assign acc_sh = {sgn, bus.add_rc[31:1]};
    assign q_sh   = {bus.add_rc[0], q[31:1]};

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc  <= 32'd0;
            q    <= 32'd0;
            q_m1 <= 1'b0;
            m    <= 32'd0;
            cnt  <= 6'd0;
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if ((state == S_IDLE) && bus.start) begin
            acc  <= 32'd0;
            q    <= bus.op_b;
            q_m1 <= 1'b0;
            m    <= bus.op_a;
            cnt  <= 6'd0;
        end else if (fire) begin
            acc  <= acc_sh;
            q    <= q_sh;
            q_m1 <= q[0];
            cnt  <= cnt + 6'd1;
            if (last) begin
                hi_r <= acc_sh;
                lo_r <= q_sh;
            end
        end
    end

    // Status flags decode registered state only; start has no path to them.
    assign bus.ready   = (state == S_IDLE);
    assign bus.busy    = (state == S_CALC);
    assign bus.done    = (state == S_DONE);
    assign bus.add_req = (state == S_CALC);
    assign bus.add_ra  = ra;
    assign bus.add_rb  = rb;
    assign bus.add_cin = cin;
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq: directed vector table, hand-written
// corner sequences, then random signed operands against a 64-bit product model.
module tb_mul_booth_seq;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    mul_booth_seq_if bus ();

    mul_booth_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Shared adder: plain 32-bit sum with carry-in.
    assign bus.add_rc = bus.add_ra + bus.add_rb + {31'd0, bus.add_cin};

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          n_accept_exp = 0;
    logic [63:0] prev_prod;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          mode;     // 0: grant tied high, 2: grant toggles 0,1,0,1...
        logic [63:0] exp_prod;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    always @(negedge clock) if (bus.done === 1'b1) n_done++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one multiply and follows it to done (or to a reset at CALC cycle abort_at).
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int mode,
                          input bit inject, input int abort_at,
                          output logic [63:0] prod, output int lat, output int ungr,
                          output int acc_wait, output bit aborted);
        bit          got;
        bit          prev_ungr;
        logic [64:0] prev_bus;
        int          stab_bad;
        int          hold_bad;
        prod = '0; lat = 0; ungr = 0; acc_wait = 0; aborted = 1'b0;
        prev_ungr = 1'b0; prev_bus = '0; stab_bad = 0; hold_bad = 0;

        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        got = 1'b0;
        for (int w = 1; w <= 8 && !got; w++) begin
            step();
            if (bus.busy === 1'b1) begin
                got = 1'b1;
                acc_wait = w;
            end
        end
        bus.start = 1'b0;
        if (!got) begin
            check("accept_timeout", 64'd0, 64'd1);
            return;
        end
        n_accept_exp++;

        got = 1'b0;
        for (int k = 1; k <= 2000 && !got; k++) begin
            if (bus.done === 1'b1) begin
                got  = 1'b1;
                lat  = k;
                prod = {bus.hi, bus.lo};
            end else begin
                if ({bus.hi, bus.lo} !== prev_prod) hold_bad++;
                if (prev_ungr && ({bus.add_ra, bus.add_rb, bus.add_cin} !== prev_bus)) stab_bad++;
                case (mode)
                    0:       bus.add_gnt = 1'b1;
                    1:       bus.add_gnt = ($urandom_range(0, 99) < 70);
                    default: bus.add_gnt = (k % 2 == 0);
                endcase
                prev_ungr = !bus.add_gnt;
                prev_bus  = {bus.add_ra, bus.add_rb, bus.add_cin};
                if (!bus.add_gnt) ungr++;
                if (inject && k == 5) begin
                    bus.start = 1'b1;
                    bus.op_a  = 32'h1234_5678;
                    bus.op_b  = 32'h8765_4321;
                end
                if (inject && k == 6) bus.start = 1'b0;
                if (abort_at == k) begin
                    reset_n = 1'b0;
                    step();
                    reset_n = 1'b1;
                    aborted = 1'b1;
                    n_accept_exp--;
                    bus.add_gnt = 1'b1;
                    return;
                end
                step();
            end
        end
        bus.add_gnt = 1'b1;
        if (!got) check("done_timeout", 64'd0, 64'd1);
        check("hilo_hold_during_calc", 64'(hold_bad), 64'd0);
        check("adder_stable_ungranted", 64'(stab_bad), 64'd0);
    endtask

    initial begin
        logic [63:0] prod;
        logic [63:0] exp;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          ungr;
        int          acc_wait;
        int          seen;
        bit          aborted;

        vecs[0] = '{32'h0000_0003, 32'hFFFF_FFFB, 0, 64'hFFFF_FFFF_FFFF_FFF1, 33};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 0, 64'h4000_0000_0000_0000, 33};
        vecs[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 64'h3FFF_FFFF_0000_0001, 33};
        vecs[3] = '{32'h0000_0000, 32'hDEAD_BEEF, 0, 64'h0000_0000_0000_0000, 33};
        vecs[4] = '{32'h0000_0005, 32'h0000_0007, 2, 64'h0000_0000_0000_0023, 65};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'h0000_0000_0000_0001, 33};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 0, 64'h0000_0000_8000_0000, 33};
        vecs[7] = '{32'h8000_0000, 32'h0000_0001, 2, 64'hFFFF_FFFF_8000_0000, 65};

        bus.start   = 1'b0;
        bus.op_a    = 32'd0;
        bus.op_b    = 32'd0;
        bus.add_gnt = 1'b1;
        prev_prod   = 64'd0;
        reset_n     = 1'b0;
        step();
        step();
        check("reset_flags", {bus.ready, bus.busy, bus.done, bus.add_req}, 4'b1000);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        reset_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            do_mul(vecs[i].a, vecs[i].b, vecs[i].mode, 1'b0, 0, prod, lat, ungr, acc_wait, aborted);
            check($sformatf("vec%0d_product", i), prod, vecs[i].exp_prod);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_latency_vs_stalls", i), 64'(lat), 64'(33 + ungr));
            if (i > 0) check($sformatf("vec%0d_back_to_back_accept", i), 64'(acc_wait), 64'd2);
            prev_prod = vecs[i].exp_prod;
        end

        // start and operand changes during CALC must not disturb the running multiply.
        do_mul(32'h0000_0003, 32'hFFFF_FFFB, 0, 1'b1, 0, prod, lat, ungr, acc_wait, aborted);
        check("inject_product", prod, 64'hFFFF_FFFF_FFFF_FFF1);
        check("inject_latency", 64'(lat), 64'd33);
        prev_prod = 64'hFFFF_FFFF_FFFF_FFF1;

        // Reset mid-CALC discards the operation.
        do_mul(32'h0000_1234, 32'h0000_5678, 0, 1'b0, 10, prod, lat, ungr, acc_wait, aborted);
        check("abort_taken", 64'(aborted), 64'd1);
        check("abort_flags", {bus.ready, bus.busy, bus.done, bus.add_req}, 4'b1000);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_adder_idle", {bus.add_ra, bus.add_rb, bus.add_cin}, 65'd0);
        prev_prod = 64'd0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) seen++;
            step();
        end
        check("abort_no_done", 64'(seen), 64'd0);

        do_mul(32'hFFFF_FFF9, 32'h0000_0009, 0, 1'b0, 0, prod, lat, ungr, acc_wait, aborted);
        check("recover_product", prod, 64'hFFFF_FFFF_FFFF_FFC1);
        check("recover_accept_from_idle", 64'(acc_wait), 64'd1);
        prev_prod = 64'hFFFF_FFFF_FFFF_FFC1;

        for (int r = 0; r < 1000; r++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 15))
                0: a = 32'h8000_0000;
                1: b = 32'h8000_0000;
                2: a = 32'h7FFF_FFFF;
                3: b = 32'hFFFF_FFFF;
                4: a = 32'd0;
                default: ;
            endcase
            exp = 64'(longint'($signed(a)) * longint'($signed(b)));
            do_mul(a, b, 1, 1'b0, 0, prod, lat, ungr, acc_wait, aborted);
            check($sformatf("rand%0d_product a=%h b=%h", r, a, b), prod, exp);
            check($sformatf("rand%0d_latency_vs_stalls", r), 64'(lat), 64'(33 + ungr));
            prev_prod = exp;
        end

        step();
        step();
        check("done_count_vs_accepts", 64'(n_done), 64'(n_accept_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
